conv_feeder: RTL

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_feeder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg -- shared definitions for the convolution feeder slice.
//   * default widths for data/bias/accumulator, memory addresses and tap count
//   * FSM state type used by conv_feeder (IDLE / RUN / DRAIN / DONE)
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned LEN_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

endpackage

// File: rtl/conv_feeder.sv
// -----------------------------------------------------------------------------
// conv_feeder -- streams len (data, weight) pairs from two synchronous memories
// into an external MAC unit and reports the accumulated sum.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   start, len               job request (sampled in IDLE) and tap count
//   base_d, base_w           data / weight start addresses
//   bias_cfg                 initial accumulator value
//   d_rd_en, d_addr          data memory read request   (data back 1 cycle later)
//   w_rd_en, w_addr          weight memory read request (data back 1 cycle later)
//   d_rdata, w_rdata         memory read data
//   u_en, u_data, u_weight,
//   u_bias                   MAC operands; MAC registers u_bias + u_data*u_weight
//   u_result                 MAC registered result
//   busy, done, acc_o        job status, one-cycle done pulse, final sum
//   job_cnt                  completed-job counter (only with CONV_FEEDER_PERF_EN)
//
// Build option: define CONV_FEEDER_PERF_EN to add the job_cnt output.
// -----------------------------------------------------------------------------
module conv_feeder
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [ADDR_WIDTH-1:0] base_d,
    input  logic [ADDR_WIDTH-1:0] base_w,
    input  logic [DATA_WIDTH-1:0] bias_cfg,
    output logic                  d_rd_en,
    output logic                  w_rd_en,
    output logic [ADDR_WIDTH-1:0] d_addr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] d_rdata,
    input  logic [DATA_WIDTH-1:0] w_rdata,
    output logic                  u_en,
    output logic [DATA_WIDTH-1:0] u_data,
    output logic [DATA_WIDTH-1:0] u_weight,
    output logic [DATA_WIDTH-1:0] u_bias,
    input  logic [DATA_WIDTH-1:0] u_result,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] acc_o
`ifdef CONV_FEEDER_PERF_EN
    ,
    output logic [31:0]           job_cnt
`endif
);

    conv_state_t           state, state_nxt;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  k_q;
    logic [ADDR_WIDTH-1:0] base_d_q;
    logic [ADDR_WIDTH-1:0] base_w_q;
    logic [DATA_WIDTH-1:0] bias_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic                  beat_q;   // read issued last cycle -> MAC beat now
    logic                  first_q;  // that read was k == 0
    logic                  done_q;

    logic                  accept;
    logic                  last_issue;

    assign accept     = (state == IDLE) && start;
    assign last_issue = (k_q == len_q - LEN_WIDTH'(1));

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q    <= '0;
            k_q      <= '0;
            base_d_q <= '0;
            base_w_q <= '0;
            bias_q   <= '0;
            acc_q    <= '0;
            beat_q   <= 1'b0;
            first_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (accept) begin
                len_q    <= len;
                base_d_q <= base_d;
                base_w_q <= base_w;
                bias_q   <= bias_cfg;
                k_q      <= '0;
            end else if (state == RUN) begin
                k_q <= k_q + LEN_WIDTH'(1);
            end

            // Memory returns data one cycle after the request, so the MAC
            // beat is simply the read strobe delayed by one cycle.
            beat_q  <= (state == RUN);
            first_q <= (state == RUN) && (k_q == '0);
            done_q  <= (state == DONE);

            if (state == DONE) begin
                acc_q <= (len_q == '0) ? bias_q : u_result;
            end
        end
    end

`ifdef CONV_FEEDER_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            job_cnt <= '0;
        end else if (done_q) begin
            job_cnt <= job_cnt + 32'd1;
        end
    end
`else
    // No job counter in the default build.
`endif

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy     = (state != IDLE);
        d_rd_en  = (state == RUN);
        w_rd_en  = (state == RUN);
        d_addr   = '0;
        w_addr   = '0;
        if (state == RUN) begin
            d_addr = base_d_q + ADDR_WIDTH'(k_q);
            w_addr = base_w_q + ADDR_WIDTH'(k_q);
        end

        u_en     = beat_q;
        u_data   = '0;
        u_weight = '0;
        u_bias   = '0;
        if (beat_q) begin
            u_data   = d_rdata;
            u_weight = w_rdata;
            // First beat seeds the MAC with the bias; later beats feed back
            // the MAC's own registered result to keep a running sum.
            u_bias   = first_q ? bias_q : u_result;
        end

        done  = done_q;
        acc_o = acc_q;
    end

endmodule
